// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a two-flop input synchroniser and a
// single-entry ready/valid holding register. Rev 1.0
`default_nettype none

module uart_receiver #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             sync1, rx;
  logic             frame_good, frame_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
    end
  end

  // The start bit is checked half a bit in; every later sample lands mid-bit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx) begin
          bit_next   = 3'd0;
          cnt_next   = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx;
          bit_next            = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = ST_STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx) begin
            frame_good = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_BREAK;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A new byte may replace one that is being consumed on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun       <= 1'b0;
      if (frame_good && (!data_out_valid || data_out_ready)) begin
        data_out       <= shift;
        data_out_valid <= 1'b1;
      end else begin
        if (frame_good) overrun <= 1'b1;
        if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a frame-level model of the receiver.
`default_nettype none

module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model state: bytes still to be delivered, their predicted arrival cycle,
  // and outstanding error pulses.
  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         exp_fe = 0;
  int         exp_ov = 0;
  int         rx_count = 0;
  logic [7:0] last_rx = 8'h00;

  logic       pv = 1'b0, pr = 1'b0, pfe = 1'b0, pov = 1'b0;
  logic [7:0] pdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, 10 cycles per bit. Valid is due ~9.5 bits + 2 sync cycles after the start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic drop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (stop && !drop) begin
      exp_q.push_back(b);
      exp_t.push_back(cyc + 97);
    end
    if (!stop) exp_fe++;
    if (stop && drop) exp_ov++;
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (10) tick();
    end
  endtask

  task automatic drained(input string name);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_fe_left"}, exp_fe, 0);
    check({name, "_ov_left"}, exp_ov, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0; pr = 1'b0; pfe = 1'b0; pov = 1'b0;
    end else begin
      if (data_out_valid && !pv) begin
        n_vec++;
        if (exp_t.size() == 0) begin
          n_err++;
          $display("FAIL valid_rise: unexpected at cycle %0d, none required", cyc);
        end else begin
          int t;
          t = exp_t.pop_front();
          if (cyc < t - 2 || cyc > t + 2) begin
            n_err++;
            $display("FAIL valid_latency: rose at cycle %0d, required %0d +-2", cyc, t);
          end
        end
      end
      if (data_out_valid && pv && !pr) check("data_stable", data_out, pdata);
      if (pv && pr) check("valid_drop_after_accept", data_out_valid, 1'b0);
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_byte: got %0h, no byte required", data_out);
        end else begin
          check("rx_byte", data_out, exp_q.pop_front());
        end
        rx_count++;
        last_rx = data_out;
      end
      if (framing_error) begin
        n_vec++;
        if (exp_fe == 0) begin
          n_err++;
          $display("FAIL framing_error: got 1 at cycle %0d, required 0", cyc);
        end else exp_fe--;
      end
      if (overrun) begin
        n_vec++;
        if (exp_ov == 0) begin
          n_err++;
          $display("FAIL overrun: got 1 at cycle %0d, required 0", cyc);
        end else exp_ov--;
      end
      if (pfe) check("fe_one_cycle", framing_error, 1'b0);
      if (pov) check("ov_one_cycle", overrun, 1'b0);
      if (framing_error || overrun) check("fe_ov_exclusive", framing_error & overrun, 1'b0);
      pv = data_out_valid; pr = data_out_ready; pdata = data_out;
      pfe = framing_error; pov = overrun;
    end
  end

  initial begin
    logic [7:0] abort_byte;
    reset = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b1;
    repeat (3) tick();
    check("reset_data", data_out, 8'h00);
    check("reset_valid", data_out_valid, 1'b0);
    check("reset_fe", framing_error, 1'b0);
    check("reset_ov", overrun, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (20) tick();
    drained("t1");
    check("t1_last", last_rx, 8'hA5);
    check("t1_count", rx_count, 1);

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (20) tick();
    drained("t2");
    check("t2_last", last_rx, 8'h55);
    check("t2_count", rx_count, 4);

    // Short glitch then a real frame
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    check("t3_glitch_count", rx_count, 4);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (20) tick();
    drained("t3");
    check("t3_last", last_rx, 8'h3C);
    check("t3_count", rx_count, 5);

    // Bad stop bit followed by a held-low break
    send_frame(8'h81, 1'b0, 1'b0);
    serial_in = 1'b0;
    repeat (40) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    drained("t4_break");
    check("t4_break_count", rx_count, 5);
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (20) tick();
    drained("t4");
    check("t4_last", last_rx, 8'h12);
    check("t4_count", rx_count, 6);

    // Overrun while the consumer stalls
    data_out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (20) tick();
    check("t5_held_valid", data_out_valid, 1'b1);
    check("t5_held_data", data_out, 8'h11);
    data_out_ready = 1'b1;
    tick();
    tick();
    check("t5_valid_dropped", data_out_valid, 1'b0);
    drained("t5");
    check("t5_last", last_rx, 8'h11);
    check("t5_count", rx_count, 7);

    // Reset in the middle of data bit 4, with a byte still held
    data_out_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    repeat (5) tick();
    check("t6_pre_valid", data_out_valid, 1'b1);
    abort_byte = 8'h5A;
    serial_in = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      serial_in = abort_byte[i];
      repeat (10) tick();
    end
    serial_in = abort_byte[4];
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("t6_rst_data", data_out, 8'h00);
    check("t6_rst_valid", data_out_valid, 1'b0);
    check("t6_rst_fe", framing_error, 1'b0);
    check("t6_rst_ov", overrun, 1'b0);
    exp_q.delete();
    exp_t.delete();
    serial_in = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    data_out_ready = 1'b1;
    repeat (80) tick();
    check("t6_no_output_after_abort", data_out_valid, 1'b0);
    check("t6_abort_count", rx_count, 7);
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (20) tick();
    drained("t6");
    check("t6_last", last_rx, 8'h7E);
    check("t6_count", rx_count, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
